// File: rtl/conv_pkg.sv
// conv_pkg: constants, types and helpers shared by the patch-capture block.
//   band_t       : PATCH captured columns (index 0 = leftmost) plus its x position
//   patch_t      : PATCH*PATCH patch, bit [r*PATCH+c] = row y+r, column x+c
//   scan_state_t : scanner states
package conv_pkg;

  localparam int PATCH      = 10;
  localparam int IMG_H      = 28;
  localparam int IMG_W      = 28;
  localparam int POS_W      = 5;
  localparam int CNT_W      = $clog2(IMG_W + 1);
  localparam int PATCH_BITS = PATCH * PATCH;

  typedef logic [IMG_H-1:0] col_t;

  typedef struct packed {
    logic [PATCH-1:0][IMG_H-1:0] cols;
    logic [POS_W-1:0]            x;
  } band_t;

  typedef logic [PATCH_BITS-1:0] patch_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } scan_state_t;

  // A programmed stride of zero still has to advance the scan.
  function automatic logic [2:0] stride_eff(input logic [2:0] s);
    if (s == 3'd0) begin
      return 3'd1;
    end else begin
      return s;
    end
  endfunction

  // True when stepping y by s would leave the band; one extra bit avoids wrap.
  function automatic logic is_last(input logic [POS_W-1:0] y, input logic [2:0] s);
    logic [POS_W:0] sum;
    sum = {1'b0, y} + {{(POS_W-2){1'b0}}, s};
    return (sum > (POS_W+1)'(IMG_H - PATCH));
  endfunction

  // Cut the PATCH x PATCH window starting at row y out of a band.
  function automatic patch_t get_patch(input band_t b, input logic [POS_W-1:0] y);
    patch_t p;
    col_t   col;
    p = '0;
    for (int c = 0; c < PATCH; c++) begin
      col = b.cols[c] >> y;
      for (int r = 0; r < PATCH; r++) begin
        p[r*PATCH + c] = col[r];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/band_fifo2.sv
// band_fifo2: two-entry FIFO of captured bands with simultaneous push/pop.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, din       : write request and band; ignored when full unless popping
//   accepted        : push was taken this cycle
//   pop             : release the head entry (ignored when empty)
//   head, next_band : oldest entry and the entry behind it
//   empty, full     : occupancy flags
module band_fifo2
  import conv_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  band_t din,
  output logic  accepted,
  input  logic  pop,
  output band_t head,
  output band_t next_band,
  output logic  empty,
  output logic  full
);

  band_t      mem_r [2];
  logic       rd_ptr_r;
  logic       wr_ptr_r;
  logic [1:0] count_r;
  logic       do_pop_s;
  logic       do_push_s;

  assign empty     = (count_r == 2'd0);
  assign full      = (count_r == 2'd2);
  assign do_pop_s  = pop & ~empty;
  // A pop in the same cycle frees a slot for an otherwise-full push.
  assign do_push_s = push & (~full | do_pop_s);
  assign accepted  = do_push_s;
  assign head      = mem_r[rd_ptr_r];
  assign next_band = mem_r[~rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/conv_patch_capture.sv
// conv_patch_capture: captures PATCH-column bands on conv_enable and scans them
// vertically, emitting PATCH x PATCH patches over a valid/ready handshake.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   frame_start, col_valid      : column strobe; frame_start marks column 0
//   col_in                      : one image column, bit r = row r
//   conv_enable                 : capture request for the band ending at this column
//   stride                      : vertical step (0 behaves as 1), latched per band
//   patch_valid/patch_ready     : output handshake
//   patch_data, x_pos, y_pos    : patch bits and its top-left position
//   last_in_band                : final patch of the current band
//   overflow                    : sticky, a capture was dropped (FIFO full)
module conv_patch_capture
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    col_valid,
  input  logic [IMG_H-1:0]        col_in,
  input  logic                    conv_enable,
  input  logic [2:0]              stride,
  output logic                    patch_valid,
  input  logic                    patch_ready,
  output logic [PATCH*PATCH-1:0]  patch_data,
  output logic [POS_W-1:0]        x_pos,
  output logic [POS_W-1:0]        y_pos,
  output logic                    last_in_band,
  output logic                    overflow
);

  logic [PATCH-1:0][IMG_H-1:0] win_r, win_s;
  logic [CNT_W-1:0]            cnt_r, cnt_s;
  logic                        capture_s;
  band_t                       cap_band_s;
  logic                        accepted_s;
  logic                        overflow_r;

  band_t       head_s, next_s;
  logic        fifo_empty_s, fifo_full_s, pop_s;
  scan_state_t state_r, state_s;
  logic [POS_W-1:0] y_r, y_s, x_r, x_s;
  logic [2:0]       stride_r, stride_s;
  logic             valid_r, valid_s, last_r, last_s;
  patch_t           data_r, data_s;

  // Column window shift and column counter; the window includes this column.
  always_comb begin
    win_s = win_r;
    cnt_s = cnt_r;
    if (col_valid) begin
      for (int c = 0; c < PATCH-1; c++) begin
        win_s[c] = win_r[c+1];
      end
      win_s[PATCH-1] = col_in;
      if (frame_start) begin
        cnt_s = CNT_W'(1);
      end else if (cnt_r == CNT_W'(IMG_W)) begin
        cnt_s = cnt_r;
      end else begin
        cnt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      win_s = win_r;
      cnt_s = cnt_r;
    end
  end

  assign capture_s       = col_valid & conv_enable & (cnt_s >= CNT_W'(PATCH));
  assign cap_band_s.cols = win_s;
  assign cap_band_s.x    = POS_W'(cnt_s - CNT_W'(PATCH));

  band_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture_s),
    .din       (cap_band_s),
    .accepted  (accepted_s),
    .pop       (pop_s),
    .head      (head_s),
    .next_band (next_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // Scanner next state and next registered outputs.
  always_comb begin
    state_s  = state_r;
    y_s      = y_r;
    x_s      = x_r;
    stride_s = stride_r;
    valid_s  = valid_r;
    data_s   = data_r;
    last_s   = last_r;
    pop_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_s  = EMIT;
          y_s      = '0;
          stride_s = stride_eff(stride);
          valid_s  = 1'b1;
          data_s   = get_patch(head_s, '0);
          x_s      = head_s.x;
          last_s   = is_last('0, stride_eff(stride));
        end else begin
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
      end
      EMIT: begin
        if (valid_r && patch_ready) begin
          if (last_r) begin
            pop_s = 1'b1;
            // A full FIFO means a second band is already queued behind the head.
            if (fifo_full_s) begin
              y_s      = '0;
              stride_s = stride_eff(stride);
              valid_s  = 1'b1;
              data_s   = get_patch(next_s, '0);
              x_s      = next_s.x;
              last_s   = is_last('0, stride_eff(stride));
            end else begin
              state_s = IDLE;
              valid_s = 1'b0;
              last_s  = 1'b0;
            end
          end else begin
            y_s    = y_r + POS_W'(stride_r);
            data_s = get_patch(head_s, y_s);
            last_s = is_last(y_s, stride_r);
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
      end
    endcase
  end

  // State, column window, counter, outputs and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_r      <= '0;
      cnt_r      <= '0;
      state_r    <= IDLE;
      y_r        <= '0;
      x_r        <= '0;
      stride_r   <= 3'd1;
      valid_r    <= 1'b0;
      data_r     <= '0;
      last_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      win_r      <= win_s;
      cnt_r      <= cnt_s;
      state_r    <= state_s;
      y_r        <= y_s;
      x_r        <= x_s;
      stride_r   <= stride_s;
      valid_r    <= valid_s;
      data_r     <= data_s;
      last_r     <= last_s;
      overflow_r <= overflow_r | (capture_s & ~accepted_s);
    end
  end

  assign patch_valid  = valid_r;
  assign patch_data   = data_r;
  assign x_pos        = x_r;
  assign y_pos        = y_r;
  assign last_in_band = last_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_conv_patch_capture.sv
module tb_conv_patch_capture;
  import conv_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   frame_start;
  logic                   col_valid;
  logic [IMG_H-1:0]       col_in;
  logic                   conv_enable;
  logic [2:0]             stride;
  logic                   patch_valid;
  logic                   patch_ready;
  logic [PATCH*PATCH-1:0] patch_data;
  logic [POS_W-1:0]       x_pos;
  logic [POS_W-1:0]       y_pos;
  logic                   last_in_band;
  logic                   overflow;

  typedef struct {
    logic [POS_W-1:0]       x;
    logic [POS_W-1:0]       y;
    logic                   last;
    logic [PATCH*PATCH-1:0] data;
  } exp_t;

  exp_t             q[$];
  logic [IMG_H-1:0] img [IMG_W];
  int               m_cnt;
  int               checks = 0;
  int               errors = 0;

  conv_patch_capture dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .col_valid    (col_valid),
    .col_in       (col_in),
    .conv_enable  (conv_enable),
    .stride       (stride),
    .patch_valid  (patch_valid),
    .patch_ready  (patch_ready),
    .patch_data   (patch_data),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .last_in_band (last_in_band),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected patches of one band, cut straight from the bench's image copy.
  task automatic push_band(input int x, input int s);
    exp_t e;
    int   y;
    bit   done;
    y = 0;
    done = 1'b0;
    while (!done) begin
      e.x    = POS_W'(x);
      e.y    = POS_W'(y);
      e.last = ((y + s) > (IMG_H - PATCH));
      e.data = '0;
      for (int r = 0; r < PATCH; r++) begin
        for (int c = 0; c < PATCH; c++) begin
          e.data[r*PATCH + c] = img[x + c][y + r];
        end
      end
      q.push_back(e);
      done = e.last;
      y = y + s;
    end
  endtask

  task automatic send_col(input bit first, input bit en, input bit expect_drop);
    frame_start = first;
    col_valid   = 1'b1;
    col_in      = IMG_H'($urandom());
    conv_enable = en;
    if (first) m_cnt = 1;
    else if (m_cnt < IMG_W) m_cnt = m_cnt + 1;
    img[m_cnt - 1] = col_in;
    if (en && (m_cnt >= PATCH) && !expect_drop)
      push_band(m_cnt - PATCH, (stride == 3'd0) ? 1 : int'(stride));
    tick();
    frame_start = 1'b0;
    col_valid   = 1'b0;
    conv_enable = 1'b0;
  endtask

  // Fresh frame: PATCH columns, conv_enable only on the last one.
  task automatic send_band_frame();
    send_col(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < PATCH - 1; i++) send_col(1'b0, 1'b0, 1'b0);
    send_col(1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_queue_empty"}, 128'(q.size()), 128'(0));
    check({tag, "_idle"}, 128'(patch_valid), 128'(0));
  endtask

  task automatic wait_y(input logic [POS_W-1:0] yv, output bit found);
    int n;
    n = 0;
    while (!(patch_valid && y_pos == yv) && n < 40) begin
      tick();
      n++;
    end
    found = patch_valid && (y_pos == yv);
  endtask

  // Scoreboard: every accepted patch is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && patch_valid && patch_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_patch observed=x%0d,y%0d expected=none", x_pos, y_pos);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("x_pos", 128'(x_pos), 128'(e.x));
        check("y_pos", 128'(y_pos), 128'(e.y));
        check("last_in_band", 128'(last_in_band), 128'(e.last));
        check("patch_data", 128'(patch_data), 128'(e.data));
      end
    end
  end

  initial begin
    logic [PATCH*PATCH-1:0] snap_data;
    logic [POS_W-1:0]       snap_x, snap_y;
    bit                     found;

    rst = 1'b1; frame_start = 1'b0; col_valid = 1'b0; col_in = '0;
    conv_enable = 1'b0; stride = 3'd2; patch_ready = 1'b1; m_cnt = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 128'(patch_valid), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_last", 128'(last_in_band), 128'(0));
    check("rst_x", 128'(x_pos), 128'(0));
    check("rst_y", 128'(y_pos), 128'(0));
    check("rst_data", 128'(patch_data), 128'(0));

    // Early enable: fewer than PATCH columns never capture.
    send_col(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < PATCH - 1; i++) send_col(1'b0, 1'b1, 1'b0);
    tick(); tick(); tick();
    check("early_valid", 128'(patch_valid), 128'(0));
    check("early_overflow", 128'(overflow), 128'(0));

    // Basic band with stride 2 and latency check.
    stride = 3'd2;
    send_band_frame();
    check("latency_write_edge", 128'(patch_valid), 128'(0));
    tick();
    check("latency_load_edge", 128'(patch_valid), 128'(1));
    drain("basic");

    // Backpressure at y=6 for five cycles.
    send_band_frame();
    wait_y(POS_W'(6), found);
    check("bp_reach_y6", 128'(found), 128'(1));
    snap_data = patch_data; snap_x = x_pos; snap_y = y_pos;
    patch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 128'(patch_valid), 128'(1));
      check("bp_data", 128'(patch_data), 128'(snap_data));
      check("bp_x", 128'(x_pos), 128'(snap_x));
      check("bp_y", 128'(y_pos), 128'(snap_y));
    end
    patch_ready = 1'b1;
    drain("backpressure");

    // Overflow: three captures with the consumer stalled, the third is dropped.
    stride = 3'd3;
    patch_ready = 1'b0;
    send_col(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < PATCH - 1; i++) send_col(1'b0, 1'b0, 1'b0);
    send_col(1'b0, 1'b1, 1'b0);
    send_col(1'b0, 1'b1, 1'b0);
    check("ovf_not_yet", 128'(overflow), 128'(0));
    send_col(1'b0, 1'b1, 1'b1);
    check("ovf_set", 128'(overflow), 128'(1));
    tick(); tick(); tick();
    patch_ready = 1'b1;
    drain("overflow");
    check("ovf_sticky", 128'(overflow), 128'(1));

    // Stride 0 behaves as 1, then stride 7 on the next column's band.
    stride = 3'd0;
    send_band_frame();
    drain("stride0");
    stride = 3'd7;
    send_col(1'b0, 1'b1, 1'b0);
    drain("stride7");

    // Reset in the middle of a band.
    stride = 3'd2;
    send_band_frame();
    wait_y(POS_W'(4), found);
    check("rst_reach_y4", 128'(found), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    check("midrst_valid", 128'(patch_valid), 128'(0));
    check("midrst_overflow", 128'(overflow), 128'(0));
    tick();
    check("midrst_still_idle", 128'(patch_valid), 128'(0));
    send_band_frame();
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_patch_capture.md
Name: conv_patch_capture

Overview:
- Receiving end of the convolution-enable interface. Consumes the binary image column stream together with the per-column conv_enable strobe.
- On each enabled column it snapshots the last PATCH columns into a band buffer. It then walks that band vertically at the programmed stride and emits PATCH x PATCH patches, each with its x/y position, over a valid/ready handshake to the clause-evaluation stage.
- Sits between the pixel feeder / enable generator and the CoTM clause array.

Parameters:
- PATCH, 10, patch width and height in pixels.
- IMG_H, 28, image height (bits per column).
- IMG_W, 28, image width (columns per frame).
- POS_W, 5, width of the x/y position outputs; must satisfy 2^POS_W > max(IMG_W, IMG_H) - PATCH.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- frame_start, in, 1: qualifies the first column of a frame; clears the column counter.
- col_valid, in, 1: col_in is valid this cycle.
- col_in, in, IMG_H: one image column; bit r is row r.
- conv_enable, in, 1: sampled only when col_valid=1; requests a band capture ending at this column.
- stride, in, 3: vertical stride in rows; the value 0 is treated as 1.
- patch_valid, out, 1: patch_data/x_pos/y_pos are valid.
- patch_ready, in, 1: the consumer accepts the patch.
- patch_data, out, PATCH*PATCH: bit [r*PATCH+c] = row y_pos+r, column x_pos+c.
- x_pos, out, POS_W: leftmost column index of the patch.
- y_pos, out, POS_W: top row index of the patch.
- last_in_band, out, 1: set with the final patch of the current band.
- overflow, out, 1: sticky; set when a capture is dropped.

Behaviour:
- Reset values: all outputs 0; column shift register 0; column counter 0; both band buffers empty; FSM in IDLE. A reset mid-scan abandons the patch in flight and all buffered bands. Reset has priority over every other input.
- Column shift register: on col_valid, shift col_in in as the newest column; the oldest of the PATCH columns drops out.
- Column counter col_cnt:
  - frame_start&col_valid loads col_cnt=1 (the column is counted as index 0).
  - Otherwise each col_valid increments col_cnt, saturating at IMG_W.
- Capture condition: col_valid & conv_enable & (col_cnt_after_update >= PATCH).
  - The window written to the buffer includes the current column, i.e. the shift result is used the same cycle.
  - Captured x = col_cnt_after_update - PATCH.
  - conv_enable while fewer than PATCH columns have been received is ignored; overflow is not set.
- Band buffer: 2-entry FIFO, each entry holding PATCH x IMG_H bits plus x.
  - A capture when both entries are full drops the new band and sets overflow (sticky until rst).
  - A capture in the same cycle that the scanner frees an entry succeeds.
- Scanner FSM:
  - IDLE: if the FIFO is non-empty, latch stride_eff = max(stride,1), set y=0, go to EMIT.
  - EMIT: drive patch_valid=1 with data for rows y..y+PATCH-1 of the head band. Outputs are registered and held stable while patch_valid & !patch_ready.
  - On handshake (patch_valid & patch_ready):
    - If y + stride_eff > IMG_H - PATCH: pop the band; go to IDLE, or directly reload y=0 and stay in EMIT if another band is queued (back-to-back, no bubble).
    - Otherwise y += stride_eff and stay in EMIT.
  - last_in_band=1 exactly when the next step of y would exceed IMG_H - PATCH.
- Stride is latched per band; changes mid-band take effect on the next band.
- Latency: first patch_valid occurs 2 cycles after the capturing column edge (FIFO write, then scanner load). Steady state is 1 patch/cycle with patch_ready held high.
- Position arithmetic is unsigned; y comparisons use POS_W+1 bits to avoid wrap.

Decomposition:
- Shared package conv_pkg holds:
  - constants PATCH, IMG_H, IMG_W, POS_W;
  - typedef band_t (PATCH x IMG_H bit array plus x);
  - typedef patch_t;
  - scan state enum {IDLE, EMIT}.
- One natural sub-module: band_fifo2, the 2-entry band FIFO with full/empty flags and simultaneous push/pop.

Test Plan:
- Basic band, PATCH=10, IMG_H=28, stride=2, patch_ready=1:
  - feed 10 columns with conv_enable only on the 10th;
  - expect patches at x=0 with y=0,2,...,18 (10 patches), last_in_band only on y=18;
  - first patch_valid 2 cycles after the capture.
- Early enable: conv_enable on columns 1-9 -> no patch_valid, overflow=0.
- Backpressure: hold patch_ready=0 for 5 cycles during EMIT -> patch_data, x_pos and y_pos stay stable; the sequence resumes with no skipped y.
- Overflow: patch_ready=0, three captures at x=0,1,2 -> bands 0 and 1 are emitted later, band 2 is never emitted, overflow=1 and stays set.
- Stride edge cases:
  - stride=0 -> step 1, 19 patches per band;
  - stride=7 -> y=0,7,14, last_in_band on y=14.
- Reset mid-scan: assert rst during y=4 of a band -> next cycle patch_valid=0, overflow=0; after a new frame_start, x restarts at 0.
